// File: rtl/swsel_pkg.sv
// ============================================================================
// Package     : swsel_pkg
// Description : Shared constants, FSM state type and circular search helper
//               for the switch selection arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package swsel_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Widest switch bank the search helper handles
    localparam int unsigned MAX_SW = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } sel_state_e;

    // Circular search over the lowest `width` bits of vec. The search visits
    // `count` positions starting at `start` (start < width) and wraps at width.
    // Returns the first set position found, or -1 when none of them is set.
    function automatic int circ_search(
        input logic [MAX_SW-1:0] vec,
        input int unsigned       start,
        input int unsigned       count,
        input int unsigned       width
    );
        int          hit;
        int unsigned pos;
        hit = -1;
        for (int unsigned k = 0; k < MAX_SW; k++) begin
            pos = start + k;
            if (pos >= width) begin
                pos = pos - width;
            end
            if ((k < count) && (hit < 0) && vec[pos[4:0]]) begin
                hit = int'(pos);
            end
        end
        return hit;
    endfunction

endpackage : swsel_pkg

`default_nettype wire

// File: rtl/switch_debounce.sv
// ============================================================================
// Module      : switch_debounce
// Description : Single-bit two-flop synchroniser followed by a debounce
//               counter. A change is accepted once the synchronised level has
//               differed from the accepted level for DEBOUNCE_CYCLES cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sw_i,
    output logic stable_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count mismatched cycles; accept the new level on the last one
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser, accepted level and counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule : switch_debounce

`default_nettype wire

// File: rtl/switch_select_arbiter.sv
// ============================================================================
// Module      : switch_select_arbiter
// Description : Synchronises and debounces N_SW slide switches and produces a
//               registered one-hot / binary selection using fixed-priority
//               (highest index) or round-robin arbitration.
//               Build option: define SWSEL_DEBOUNCE_EN to instantiate the
//               per-switch debounce counters; otherwise the synchronised
//               levels feed the arbiter directly.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_select_arbiter
    import swsel_pkg::*;
#(
    parameter  int N_SW            = 8,
    parameter  int DEBOUNCE_CYCLES = 16,
    localparam int IDX_W           = $clog2(N_SW)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_SW-1:0]  sw,
    input  logic             mode,
    input  logic             advance,
    output logic [N_SW-1:0]  sel_onehot,
    output logic [IDX_W-1:0] sel_idx,
    output logic             sel_valid,
    output logic             sel_changed
);

    logic [N_SW-1:0] stable;

    // Unsupported configurations leave this empty marker in the hierarchy
    if ((DEBOUNCE_CYCLES < 1) || (N_SW < 2) || (N_SW > 32)) begin : g_unsupported_cfg
    end

`ifdef SWSEL_DEBOUNCE_EN
    for (genvar i = 0; i < N_SW; i++) begin : g_debounce
        switch_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk      (clk),
            .reset_n  (reset_n),
            .sw_i     (sw[i]),
            .stable_o (stable[i])
        );
    end
`else
    logic [N_SW-1:0] sync1_q;
    logic [N_SW-1:0] sync2_q;

    // Two-flop synchroniser only; its output is taken as the accepted level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sw;
            sync2_q <= sync1_q;
        end
    end

    assign stable = sync2_q;
`endif

    sel_state_e       state_q;
    sel_state_e       state_d;
    logic [IDX_W-1:0] sel_idx_q;
    logic [IDX_W-1:0] sel_idx_d;
    logic [N_SW-1:0]  onehot_q;
    logic [N_SW-1:0]  onehot_d;
    logic             changed_q;
    logic             changed_d;
    logic [IDX_W-1:0] hi_idx;
    int unsigned      rr_start;
    int               hit;

    // Highest-index active switch for fixed-priority mode
    always_comb begin
        hi_idx = '0;
        for (int i = 0; i < N_SW; i++) begin
            if (stable[i]) begin
                hi_idx = IDX_W'(i);
            end
        end
    end

    // Selection FSM: next state, next index and change detection
    always_comb begin
        state_d   = state_q;
        sel_idx_d = sel_idx_q;
        hit       = -1;
        rr_start  = (sel_idx_q == IDX_W'(N_SW - 1)) ? 0 : int'(sel_idx_q) + 1;
        if (stable == '0) begin
            state_d   = IDLE;
            sel_idx_d = '0;
        end else if (mode == MODE_FIXED) begin
            state_d   = HOLD;
            sel_idx_d = hi_idx;
        end else begin
            case (state_q)
                IDLE: begin
                    // Entry picks the first active bit at or after the last index
                    hit = circ_search(MAX_SW'(stable), int'(sel_idx_q), N_SW, N_SW);
                    if (hit >= 0) begin
                        state_d   = HOLD;
                        sel_idx_d = IDX_W'(hit);
                    end
                end
                HOLD: begin
                    // A drop and an advance together still cost one step only
                    if (!stable[sel_idx_q] || advance) begin
                        hit = circ_search(MAX_SW'(stable), rr_start, N_SW - 1, N_SW);
                        if (hit >= 0) begin
                            sel_idx_d = IDX_W'(hit);
                        end else if (!stable[sel_idx_q]) begin
                            state_d   = IDLE;
                            sel_idx_d = '0;
                        end
                    end
                end
                default: begin
                    state_d   = IDLE;
                    sel_idx_d = '0;
                end
            endcase
        end
        onehot_d  = N_SW'(1) << sel_idx_d;
        changed_d = (sel_idx_d != sel_idx_q) || (state_d != state_q);
    end

    // Selection output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sel_idx_q <= '0;
            onehot_q  <= N_SW'(1);
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_idx_q <= sel_idx_d;
            onehot_q  <= onehot_d;
            changed_q <= changed_d;
        end
    end

    assign sel_onehot  = onehot_q;
    assign sel_idx     = sel_idx_q;
    assign sel_valid   = (state_q == HOLD);
    assign sel_changed = changed_q;

endmodule : switch_select_arbiter

`default_nettype wire

// File: tb/tb_switch_select_arbiter.sv
// ============================================================================
// Module      : tb_switch_select_arbiter
// Description : Self-checking bench for switch_select_arbiter with a
//               cycle-level behavioural reference model. Works with and
//               without SWSEL_DEBOUNCE_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_switch_select_arbiter;

    localparam int N  = 8;
    localparam int DB = 4;
`ifdef SWSEL_DEBOUNCE_EN
    localparam bit DB_EN = 1'b1;
    localparam int LAT   = 2 + DB + 1;
`else
    localparam bit DB_EN = 1'b0;
    localparam int LAT   = 3;
`endif

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] sw      = 8'h00;
    logic       mode    = 1'b0;
    logic       advance = 1'b0;
    logic [7:0] sel_onehot;
    logic [2:0] sel_idx;
    logic       sel_valid;
    logic       sel_changed;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    switch_select_arbiter #(
        .N_SW            (N),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sw          (sw),
        .mode        (mode),
        .advance     (advance),
        .sel_onehot  (sel_onehot),
        .sel_idx     (sel_idx),
        .sel_valid   (sel_valid),
        .sel_changed (sel_changed)
    );

    // ---------------- reference model ----------------
    logic [7:0] m_s1, m_s2, m_stable;
    int         m_run [8];
    int         m_idx;
    bit         m_valid, m_changed;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_stable = 0;
        for (int i = 0; i < 8; i++) m_run[i] = 0;
        m_idx = 0; m_valid = 0; m_changed = 0;
    endtask

    // Accepted switch levels the arbiter acts on at the next clock
    function automatic logic [7:0] m_view();
        return DB_EN ? m_stable : m_s2;
    endfunction

    task automatic model_update();
        logic [7:0] st;
        int nxt;
        bit nval;
        int h;
        if (!reset_n) begin
            model_reset();
            return;
        end
        st = m_view();
        nxt = m_idx;
        nval = m_valid;
        if (st == 8'h00) begin
            nxt = 0; nval = 0;
        end else if (mode == 1'b0) begin
            for (int i = 0; i < 8; i++) if (st[i]) nxt = i;
            nval = 1;
        end else if (!m_valid) begin
            for (int k = 0; k < 8; k++) begin
                h = (m_idx + k) % 8;
                if (st[h]) begin nxt = h; break; end
            end
            nval = 1;
        end else if (!st[m_idx] || advance) begin
            for (int k = 1; k < 8; k++) begin
                h = (m_idx + k) % 8;
                if (st[h]) begin nxt = h; break; end
            end
        end
        m_changed = (nxt != m_idx) || (nval != m_valid);
        m_idx = nxt;
        m_valid = nval;
        // A level is accepted after DB consecutive disagreeing cycles
        for (int i = 0; i < 8; i++) begin
            if (m_s2[i] != m_stable[i]) begin
                m_run[i]++;
                if (m_run[i] >= DB) begin
                    m_stable[i] = m_s2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = sw;
    endtask

    // One clock: model follows the rising edge, bench resumes on the falling edge
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int lat;
        int pulses;
        reset_n = 0; sw = 8'hFF; mode = 0; advance = 0;
        model_reset();
        repeat (3) step();
        n_checks++; if (sel_onehot !== 8'h01) begin n_err++; $display("FAIL reset_onehot: got %h want 01", sel_onehot); end
        n_checks++; if (sel_idx !== 3'd0) begin n_err++; $display("FAIL reset_idx: got %0d want 0", sel_idx); end
        n_checks++; if (sel_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", sel_valid); end
        n_checks++; if (sel_changed !== 1'b0) begin n_err++; $display("FAIL reset_changed: got %b want 0", sel_changed); end
        reset_n = 1;
        lat = 0; pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            n_checks++;
            if (sel_idx !== 3'(m_idx) || sel_valid !== m_valid || sel_changed !== m_changed) begin
                n_err++;
                $display("FAIL release_model cyc%0d: got idx=%0d v=%b c=%b want idx=%0d v=%b c=%b",
                         k, sel_idx, sel_valid, sel_changed, m_idx, m_valid, m_changed);
            end
            if (sel_changed === 1'b1) begin
                pulses++;
                if (lat == 0) lat = k;
            end
        end
        n_checks++; if (lat != LAT) begin n_err++; $display("FAIL release_latency: got %0d want %0d", lat, LAT); end
        n_checks++; if (pulses != 1) begin n_err++; $display("FAIL release_pulses: got %0d want 1", pulses); end
        n_checks++; if (sel_idx !== 3'd7 || sel_onehot !== 8'h80) begin n_err++; $display("FAIL release_sel: got idx=%0d oh=%h want 7/80", sel_idx, sel_onehot); end
    endtask

    task automatic test_fixed_bounce();
        int pulses;
        mode = 0; sw = 8'h14;
        repeat (LAT + 3) step();
        n_checks++; if (sel_idx !== 3'd4 || sel_onehot !== 8'h10) begin n_err++; $display("FAIL fixed_initial: got idx=%0d oh=%h want 4/10", sel_idx, sel_onehot); end
        sw = 8'h04; step(); step(); sw = 8'h14;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (sel_changed === 1'b1) pulses++;
            n_checks++;
            if (sel_idx !== 3'(m_idx) || sel_changed !== m_changed) begin
                n_err++;
                $display("FAIL bounce_model: got idx=%0d c=%b want idx=%0d c=%b", sel_idx, sel_changed, m_idx, m_changed);
            end
        end
        n_checks++; if (pulses != (DB_EN ? 0 : 2)) begin n_err++; $display("FAIL bounce_pulses: got %0d want %0d", pulses, DB_EN ? 0 : 2); end
        n_checks++; if (sel_idx !== 3'd4) begin n_err++; $display("FAIL bounce_idx: got %0d want 4", sel_idx); end
        sw = 8'h04;
        repeat (6) step();
        repeat (LAT) step();
        n_checks++; if (sel_idx !== 3'd2 || sel_valid !== 1'b1 || sel_onehot !== 8'h04) begin n_err++; $display("FAIL fixed_drop: got idx=%0d v=%b oh=%h want 2/1/04", sel_idx, sel_valid, sel_onehot); end
    endtask

    task automatic test_rr_advance();
        int pulses;
        int exp_seq [3] = '{3, 5, 0};
        sw = 8'h00;
        repeat (LAT + 2) step();
        mode = 1; sw = 8'h29;
        repeat (LAT + 2) step();
        n_checks++; if (sel_idx !== 3'd0 || sel_valid !== 1'b1) begin n_err++; $display("FAIL rr_entry: got idx=%0d v=%b want 0/1", sel_idx, sel_valid); end
        for (int a = 0; a < 3; a++) begin
            pulses = 0;
            advance = 1; step(); advance = 0;
            if (sel_changed === 1'b1) pulses++;
            repeat (3) begin step(); if (sel_changed === 1'b1) pulses++; end
            n_checks++;
            if (sel_idx !== 3'(exp_seq[a]) || pulses != 1 || sel_onehot !== 8'(1 << exp_seq[a])) begin
                n_err++;
                $display("FAIL rr_advance%0d: got idx=%0d pulses=%0d want idx=%0d pulses=1", a, sel_idx, pulses, exp_seq[a]);
            end
        end
        sw = 8'hA9; pulses = 0;
        repeat (LAT + 2) begin step(); if (sel_changed === 1'b1) pulses++; end
        n_checks++; if (sel_idx !== 3'd0 || pulses != 0) begin n_err++; $display("FAIL rr_hold_new_bit: got idx=%0d pulses=%0d want 0/0", sel_idx, pulses); end
    endtask

    task automatic test_drop_with_advance();
        int pulses;
        logic [7:0] v;
        sw = 8'h29;
        repeat (LAT + 2) step();
        repeat (2) begin advance = 1; step(); advance = 0; repeat (2) step(); end
        n_checks++; if (sel_idx !== 3'd5) begin n_err++; $display("FAIL drop_setup: got idx=%0d want 5", sel_idx); end
        sw = 8'h09;
        for (int k = 0; k < 40; k++) begin
            v = m_view();
            if (!v[5]) break;
            step();
        end
        pulses = 0;
        advance = 1; step(); advance = 0;
        if (sel_changed === 1'b1) pulses++;
        repeat (4) begin step(); if (sel_changed === 1'b1) pulses++; end
        n_checks++; if (sel_idx !== 3'd0 || pulses != 1) begin n_err++; $display("FAIL drop_advance: got idx=%0d pulses=%0d want 0/1", sel_idx, pulses); end
    endtask

    task automatic test_clear_all();
        int pulses;
        sw = 8'h00; pulses = 0;
        repeat (LAT + 3) begin step(); if (sel_changed === 1'b1) pulses++; end
        n_checks++;
        if (sel_valid !== 1'b0 || sel_idx !== 3'd0 || sel_onehot !== 8'h01 || pulses != 1) begin
            n_err++;
            $display("FAIL clear_all: got v=%b idx=%0d oh=%h pulses=%0d want 0/0/01/1", sel_valid, sel_idx, sel_onehot, pulses);
        end
        sw = 8'h08;
        repeat (LAT + 2) step();
        n_checks++; if (sel_idx !== 3'd3 || sel_valid !== 1'b1) begin n_err++; $display("FAIL single_entry: got idx=%0d v=%b want 3/1", sel_idx, sel_valid); end
        pulses = 0;
        advance = 1; step(); advance = 0;
        if (sel_changed === 1'b1) pulses++;
        repeat (3) begin step(); if (sel_changed === 1'b1) pulses++; end
        n_checks++; if (sel_idx !== 3'd3 || pulses != 0) begin n_err++; $display("FAIL lone_advance: got idx=%0d pulses=%0d want 3/0", sel_idx, pulses); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        mode = 0; sw = 8'h88;
        if (DB_EN) begin
            for (int k = 0; k < 40; k++) begin
                if (m_run[7] == 2) break;
                step();
            end
        end else begin
            step();
        end
        #2 reset_n = 0;
        #1;
        model_reset();
        n_checks++;
        if (sel_onehot !== 8'h01 || sel_idx !== 3'd0 || sel_valid !== 1'b0 || sel_changed !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got oh=%h idx=%0d v=%b c=%b want 01/0/0/0", sel_onehot, sel_idx, sel_valid, sel_changed);
        end
        sw = 8'h00;
        repeat (2) step();
        reset_n = 1; pulses = 0;
        repeat (8) begin step(); if (sel_changed === 1'b1) pulses++; end
        n_checks++; if (pulses != 0 || sel_valid !== 1'b0) begin n_err++; $display("FAIL release_quiet: got pulses=%0d v=%b want 0/0", pulses, sel_valid); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 7) == 0) sw = 8'($urandom);
            else if ($urandom_range(0, 5) == 0) sw[$urandom_range(0, 7)] ^= 1'b1;
            if ($urandom_range(0, 49) == 0) mode = ~mode;
            advance = ($urandom_range(0, 4) == 0);
            step();
            n_checks++;
            if (sel_idx !== 3'(m_idx) || sel_valid !== m_valid || sel_changed !== m_changed ||
                sel_onehot !== 8'(1 << m_idx)) begin
                n_err++;
                $display("FAIL random cyc%0d: got idx=%0d oh=%h v=%b c=%b want idx=%0d v=%b c=%b",
                         k, sel_idx, sel_onehot, sel_valid, sel_changed, m_idx, m_valid, m_changed);
            end
        end
        advance = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_fixed_bounce();
        test_rr_advance();
        test_drop_with_advance();
        test_clear_all();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_switch_select_arbiter

`default_nettype wire
